// File: rtl/seq_transmitter_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
// Holds the FSM state encoding and the length-clamp rule.
package seq_transmitter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A length of zero, or one longer than the pattern, means "send the whole pattern".
   function automatic int clamp_len(input int len, input int w);
      return ((len == 0) || (len > w)) ? w : len;
   endfunction

endpackage

// File: rtl/seq_transmitter_if.sv
// Control/stream bundle between a transmitter and whoever drives it.
// The master issues start/adv/abort; the slave returns the serial bit and status.
interface seq_transmitter_if #(
   parameter int W  = 8,
   parameter int LW = $clog2(W) + 1
);
   logic          start;
   logic [W-1:0]  pattern;
   logic [LW-1:0] len;
   logic          rpt;
   logic          adv;
   logic          abort;
   logic          w;
   logic          busy;
   logic          done;
   logic [LW-1:0] bit_cnt;

   modport master (
      output start, pattern, len, rpt, adv, abort,
      input  w, busy, done, bit_cnt
   );

   modport slave (
      input  start, pattern, len, rpt, adv, abort,
      output w, busy, done, bit_cnt
   );
endinterface

// File: rtl/seq_transmitter_piso_shift.sv
// W-bit parallel-in serial-out register, MSB first.
// Load wins over shift; a shift fills the vacated LSB with 0.
module piso_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_din,
   output logic         o_msb
);
   logic [W-1:0] r_shreg;

   always_ff @(posedge clk) begin
      if (reset)        r_shreg <= '0;
      else if (i_load)  r_shreg <= i_din;
      else if (i_shift) r_shreg <= {r_shreg[W-2:0], 1'b0};
   end

   assign o_msb = r_shreg[W-1];
endmodule

// File: rtl/seq_transmitter.sv
// Serialises a latched pattern onto w, one bit per adv strobe, optionally repeating.
// Moore outputs: everything visible is decoded from the state and registers.
module seq_transmitter
   import seq_transmitter_pkg::*;
#(
   parameter int W  = 8,
   parameter int LW = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             reset,
   seq_transmitter_if.slave bus
);
   state_t        r_state, w_next;
   logic [LW-1:0] r_cnt, r_len_q;
   logic [W-1:0]  r_pat_q;
   logic          r_rpt_q;
   logic          w_load, w_shift, w_msb, w_accept, w_step;
   logic [W-1:0]  w_din;
   logic [LW-1:0] w_eff_len;

   assign w_eff_len = LW'(clamp_len(int'(bus.len), W));
   assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.abort;
   assign w_step    = (r_state == ST_SEND) && bus.adv && !bus.abort;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_din   = bus.pattern;
      case (r_state)
         ST_IDLE: if (w_accept) begin
            w_next = ST_SEND;
            w_load = 1'b1;
         end
         ST_SEND: if (w_step) begin
            if (r_cnt > LW'(1)) begin
               w_shift = 1'b1;
            end else if (r_rpt_q) begin
               w_load = 1'b1;
               w_din  = r_pat_q;
            end else begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      // abort beats start, adv and completion alike
      if (bus.abort) w_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_len_q <= '0;
         r_pat_q <= '0;
         r_rpt_q <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= w_eff_len;
         r_len_q <= w_eff_len;
         r_pat_q <= bus.pattern;
         r_rpt_q <= bus.rpt;
      end else if (w_step) begin
         if (r_cnt > LW'(1)) r_cnt <= r_cnt - LW'(1);
         else if (r_rpt_q)   r_cnt <= r_len_q;
      end
   end

   piso_shift #(.W(W)) u_piso (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_din   (w_din),
      .o_msb   (w_msb)
   );

   assign bus.w       = (r_state == ST_SEND) ? w_msb : 1'b0;
   assign bus.busy    = (r_state == ST_SEND);
   assign bus.done    = (r_state == ST_DONE);
   assign bus.bit_cnt = (r_state == ST_SEND) ? r_cnt : '0;
endmodule

// File: doc/seq_transmitter.md
SEQ_TRANSMITTER -- requirements
Module: seq_transmitter

Interface
REQ-001 Parameter: W, default 8, pattern width in bits (4..16).
REQ-002 Parameter: LW, default clog2(W)+1, width of the length field and the bit counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin transmission; sampled only in IDLE.
REQ-006 pattern  input  W  bits to send, MSB first.
REQ-007 len  input  LW  number of bits to send; 0 or any value >W is treated as W.
REQ-008 rpt  input  1  when 1 at start, the pattern is resent continuously until abort.
REQ-009 adv  input  1  bit-advance strobe; one bit is consumed per cycle with adv=1 in SEND.
REQ-010 abort  input  1  terminates any transmission.
REQ-011 w  output  1  serial bit stream that feeds a sequence detector's w input.
REQ-012 busy  output  1  high in SEND.
REQ-013 done  output  1  one-cycle pulse on normal (non-repeat) completion.
REQ-014 bit_cnt  output  LW  bits remaining in the current pass, including the bit on w.

Function
REQ-015 States: IDLE, SEND, DONE; registered state; outputs decoded from state and registers only (Moore).
REQ-016 IDLE: w=0, busy=0, done=0, bit_cnt=0.
REQ-017 IDLE with start=1 and abort=0: latch pattern into pat_q and shreg, latch effective len into len_q and cnt, latch rpt into rpt_q; next state SEND.
REQ-018 SEND: w=shreg[W-1], busy=1, bit_cnt=cnt; first bit appears on w the cycle after start is accepted.
REQ-019 SEND with adv=1 and cnt>1: shreg shifts left by one with 0 fill; cnt decrements by 1.
REQ-020 SEND with adv=1 and cnt==1 and rpt_q=1: wrap-around, shreg<=pat_q, cnt<=len_q, state stays SEND, no done pulse.
REQ-021 SEND with adv=1 and cnt==1 and rpt_q=0: next state DONE.
REQ-022 SEND with adv=0: shreg, cnt and w hold.
REQ-023 DONE: done=1, w=0, busy=0, bit_cnt=0 for exactly one cycle; next state IDLE unconditionally; start in DONE is ignored.
REQ-024 start in SEND is ignored; pattern, len and rpt changes after acceptance have no effect.
REQ-025 abort=1 in any state: next state IDLE, no done pulse; abort wins over simultaneous start, adv or completion.
REQ-026 Bit latency: bit k (0-based, MSB first) is on w from the cycle after the k-th accepted adv until the (k+1)-th accepted adv.

Reset
REQ-027 reset=1 at a clock edge forces state IDLE and clears shreg, pat_q, cnt, len_q and rpt_q.
REQ-028 After reset: w=0, busy=0, done=0, bit_cnt=0; reset overrides abort, start and adv.
REQ-029 Reset mid-SEND discards the transmission with no done pulse.

Structure
REQ-030 A shared package holds the state encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2) and the len-clamp helper; it is shared with the detector blocks' testbenches.
REQ-031 One sub-module, piso_shift (W-bit parallel-in serial-out register with load and shift enables), holds shreg; the FSM and counter live in seq_transmitter.

Verification
REQ-032 pattern=8'b1101_0000, len=4, rpt=0, start, then 4 adv pulses -> w=1,1,0,1; bit_cnt=4,3,2,1; done pulses once after the 4th adv; then IDLE with w=0.
REQ-033 len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 sent, then done.
REQ-034 rpt=1, len=3, pattern=8'b0110_0000, 7 adv -> w=0,1,1,0,1,1,0; no done; abort -> IDLE next cycle, busy=0, no done.
REQ-035 start held high during SEND and DONE -> no restart until IDLE; the new start is accepted only on the cycle after DONE.
REQ-036 reset asserted after 2 of 5 bits -> next cycle w=0, busy=0, bit_cnt=0, done never asserted.
REQ-037 End-to-end: seq_transmitter w drives a detector instance -> detector z asserts exactly on the cycles its sequence specification requires.
